// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: command encodings, FSM states, defaults.
package stack_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'b00,
        OP_POP   = 2'b01,
        OP_PEEK  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

endpackage

// File: rtl/stack_mem.sv
// Backing store for the entries below top-of-stack: (DEPTH-1) x WIDTH simple
// dual-port RAM, one write port, one registered read port, contents not reset.
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH-1];

    // Write port and 1-cycle-latency read port.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/operand_stack.sv
// Operand stack with a TOS register over a synchronous RAM. A POP of a deeper
// stack spends one REFILL cycle waiting for the RAM read of the next entry.
// Optional feature macro: OPERAND_STACK_GUARD_EN (reports overflow/underflow).
module operand_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [1:0]             req_op,
    input  logic [WIDTH-1:0]       req_data,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic [WIDTH-1:0]       tos,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   err_ovf,
    output logic                   err_unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef OPERAND_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    state_e           state, next_state;
    logic [WIDTH-1:0] tos_q;
    logic [CW-1:0]    count_q;
    logic             ovf_q, unf_q;
    logic             accept;
    op_e              op;
    logic             mem_we, mem_re;
    logic [AW-1:0]    mem_wr_addr, mem_rd_addr;
    logic [WIDTH-1:0] mem_rd_data;

    assign op        = op_e'(req_op);
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign tos       = tos_q;
    assign count     = count_q;
    assign req_ready = (state == IDLE);
    assign err_ovf   = GUARD & ovf_q;
    assign err_unf   = GUARD & unf_q;

    // Old TOS spills to the slot just above the RAM's current top; a deep POP
    // reads the entry that becomes the new TOS.
    assign mem_wr_addr = AW'(count_q - CW'(1));
    assign mem_rd_addr = AW'(count_q - CW'(2));

    stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (mem_wr_addr),
        .wr_data (tos_q),
        .rd_en   (mem_re),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_rd_data)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state, command acceptance and RAM port control.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        case (state)
            IDLE: begin
                accept = req_valid;
                if (req_valid && op == OP_PUSH && !full && !empty) mem_we = 1'b1;
                if (req_valid && op == OP_POP && count_q >= CW'(2)) begin
                    mem_re     = 1'b1;
                    next_state = REFILL;
                end
            end
            REFILL: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: TOS, occupancy, sticky error flags and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            tos_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            if (state == REFILL) begin
                tos_q   <= mem_rd_data;
                count_q <= count_q - CW'(1);
            end
            if (accept) begin
                case (op)
                    OP_PUSH: begin
                        if (!full) begin
                            tos_q   <= req_data;
                            count_q <= count_q + CW'(1);
                        end else begin
                            rsp_err <= GUARD;
                            ovf_q   <= ovf_q | GUARD;
                        end
                    end
                    OP_POP: begin
                        if (empty) begin
                            rsp_err <= GUARD;
                            unf_q   <= unf_q | GUARD;
                        end else begin
                            rsp_data <= tos_q;
                            if (count_q == CW'(1)) begin
                                tos_q   <= '0;
                                count_q <= '0;
                            end
                        end
                    end
                    OP_PEEK: begin
                        rsp_data <= tos_q;
                        rsp_err  <= GUARD & empty;
                    end
                    OP_CLEAR: begin
                        tos_q   <= '0;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack: a reference stack model predicts every
// response into a scoreboard queue; a monitor pops and compares on each pulse.
module tb_operand_stack;
    import stack_pkg::*;

`ifdef OPERAND_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, rsp_valid, rsp_err, full, empty, err_ovf, err_unf;
    logic [7:0] rsp_data, tos;
    logic [4:0] count;

    typedef struct packed { logic [7:0] data; logic err; } exp_t;
    exp_t       sb[$];
    logic [7:0] m[$];
    logic       m_ovf = 1'b0, m_unf = 1'b0;
    int         errors = 0, checks = 0;

    operand_stack #(.WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_data(req_data), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .tos(tos), .count(count),
        .full(full), .empty(empty), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    // Response monitor: every pulse must match the oldest predicted response.
    always @(negedge clk) begin
        if (rsp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got data=%02h err=%0b, none expected", rsp_data, rsp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_data !== e.data || rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL rsp: got data=%02h err=%0b, want data=%02h err=%0b",
                             rsp_data, rsp_err, e.data, e.err);
                end
            end
        end else if (rsp_data !== 8'h00 || rsp_err !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL rsp_idle: data=%02h err=%0b while rsp_valid=0", rsp_data, rsp_err);
        end
    end

    // Predict the response of one command from the reference model.
    task automatic predict(input logic [1:0] op, input logic [7:0] d);
        exp_t e;
        e = '{data: 8'h00, err: 1'b0};
        case (op)
            2'b00: if (m.size() == 16) begin e.err = GUARD; m_ovf |= GUARD; end
                   else m.push_back(d);
            2'b01: if (m.size() == 0) begin e.err = GUARD; m_unf |= GUARD; end
                   else e.data = m.pop_back();
            2'b10: if (m.size() == 0) e.err = GUARD; else e.data = m[m.size()-1];
            default: begin m.delete(); m_ovf = 1'b0; m_unf = 1'b0; end
        endcase
        sb.push_back(e);
    endtask

    // Drive one command: wait (bounded) for ready at a falling edge, hold it
    // through the accepting rising edge, then drop req_valid.
    task automatic issue(input logic [1:0] op, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: req_ready=%0b, want 1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_data = d;
        predict(op, d);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({count, tos, rsp_valid, req_ready, empty, full, err_ovf, err_unf} !==
            {5'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: count=%0d tos=%02h rv=%0b rdy=%0b e=%0b f=%0b ovf=%0b unf=%0b, want 0 00 0 1 1 0 0 0",
                     count, tos, rsp_valid, req_ready, empty, full, err_ovf, err_unf);
        end
    endtask

    task automatic test_push();
        issue(OP_PUSH, 8'h11); issue(OP_PUSH, 8'h22); issue(OP_PUSH, 8'h33);
        @(negedge clk);
        checks++;
        if (count !== 5'd3 || tos !== 8'h33) begin
            errors++;
            $display("FAIL push3: count=%0d tos=%02h, want 3 33", count, tos);
        end
    endtask

    task automatic test_pop();
        for (int i = 0; i < 3; i++) begin
            issue(OP_POP, 8'h00);
            @(negedge clk);
            checks++;
            if (req_ready !== (i == 2)) begin
                errors++;
                $display("FAIL pop_ready_n1[%0d]: req_ready=%0b, want %0b", i, req_ready, i == 2);
            end
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL pop_ready_n2[%0d]: req_ready=%0b, want 1", i, req_ready);
            end
        end
        checks++;
        if (count !== 5'd0 || tos !== 8'h00 || empty !== 1'b1) begin
            errors++;
            $display("FAIL pop_empty: count=%0d tos=%02h empty=%0b, want 0 00 1", count, tos, empty);
        end
    endtask

    task automatic test_pop_empty();
        issue(OP_POP, 8'h00);
        issue(OP_PEEK, 8'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (err_unf !== m_unf || err_ovf !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL unf_flag: err_unf=%0b err_ovf=%0b count=%0d, want %0b 0 0", err_unf, err_ovf, count, m_unf);
        end
    endtask

    task automatic test_full();
        issue(OP_CLEAR, 8'h00);
        @(negedge clk);
        checks++;
        if (err_unf !== 1'b0) begin
            errors++;
            $display("FAIL clear_unf: err_unf=%0b, want 0", err_unf);
        end
        for (int i = 0; i < 16; i++) issue(OP_PUSH, 8'hC0 + 8'(i));
        @(negedge clk);
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || tos !== 8'hCF) begin
            errors++;
            $display("FAIL full16: full=%0b count=%0d tos=%02h, want 1 16 CF", full, count, tos);
        end
        issue(OP_PUSH, 8'hAA);
        issue(OP_PEEK, 8'h00);
        @(negedge clk);
        checks++;
        if (err_ovf !== m_ovf || tos !== 8'hCF || count !== 5'd16) begin
            errors++;
            $display("FAIL ovf: err_ovf=%0b tos=%02h count=%0d, want %0b CF 16", err_ovf, tos, count, m_ovf);
        end
        // Drain to prove the spilled entries survive in RAM in order.
        for (int i = 0; i < 16; i++) issue(OP_POP, 8'h00);
        issue(OP_CLEAR, 8'h00);
        @(negedge clk);
        checks++;
        if (err_ovf !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL clear_ovf: err_ovf=%0b empty=%0b, want 0 1", err_ovf, empty);
        end
    endtask

    task automatic test_reset_refill();
        for (int i = 0; i < 5; i++) issue(OP_PUSH, 8'h40 + 8'(i));
        issue(OP_POP, 8'h00);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        m.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 5'd0 || tos !== 8'h00 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_refill: count=%0d tos=%02h rdy=%0b rv=%0b, want 0 00 1 0",
                     count, tos, req_ready, rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        issue(OP_PUSH, 8'h01); issue(OP_PUSH, 8'h02); issue(OP_PUSH, 8'h03);
        issue(OP_POP, 8'h00);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL refill_ready: req_ready=%0b, want 0", req_ready);
        end
        req_valid = 1'b1; req_op = OP_PUSH; req_data = 8'h55;
        predict(OP_PUSH, 8'h55);
        @(posedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (count !== 5'd3 || tos !== 8'h55) begin
            errors++;
            $display("FAIL push_once: count=%0d tos=%02h, want 3 55", count, tos);
        end
        for (int i = 0; i < 3; i++) issue(OP_POP, 8'h00);
    endtask

    initial begin
        test_reset();
        test_push();
        test_pop();
        test_pop_empty();
        test_full();
        test_reset_refill();
        test_back_to_back();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rsp_missing: %0d responses outstanding, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
